call_ret_stack: RTL and testbench
=================================

Name: call_ret_stack

Overview:
- Return-address stack for the program-flow unit; the return-side counterpart of the jump path.
- On CALL it pushes the return address (pc+1) and redirects the PC to the call target.
- On RET it pops the most recent return address and redirects the PC back to it.
- Sits beside the jump unit in ALU/program_flow. Its registered new_pc/pc_load pair feeds the PC mux with one-cycle latency.

Parameters:
ADDR_W, 20, program-counter / address width in bits
DEPTH, 16, number of return-address entries (power of two, >=2)
CNT_W, 5, width of depth counter; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
call_i  input  1  CALL request, sampled on the clk edge
ret_i  input  1  RET request, sampled on the clk edge
pc  input  ADDR_W  PC of the current instruction
call_address  input  ADDR_W  CALL target address
err_clr_i  input  1  clears sticky error flags
new_pc  output  ADDR_W  registered redirect address
pc_load  output  1  one-cycle strobe: PC mux takes new_pc
top_addr_o  output  ADDR_W  current top entry; 0 when empty
depth_o  output  CNT_W  number of valid entries, 0..DEPTH
full_o  output  1  depth_o == DEPTH (combinational from counter)
empty_o  output  1  depth_o == 0 (combinational from counter)
ovf_err_o  output  1  sticky: CALL attempted while full
unf_err_o  output  1  sticky: RET attempted while empty
ill_err_o  output  1  sticky: call_i and ret_i asserted together

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-operation):
  - depth counter = 0, new_pc = 0, pc_load = 0, all error flags = 0.
  - Stack RAM is not reset; its contents are don't-care until written.
- Storage: DEPTH x ADDR_W register array, entry index 0..DEPTH-1. The top entry is entry[depth-1].
- Every cycle, pc_load defaults to 0. It is high for exactly one cycle after each accepted operation.
- Accepted CALL (call_i=1, ret_i=0, depth<DEPTH):
  - entry[depth] <= pc + 1, truncated to ADDR_W bits, so 0xFFFFF wraps to 0x00000.
  - depth <= depth + 1.
  - new_pc <= call_address; pc_load <= 1.
- Rejected CALL (call_i=1, ret_i=0, depth==DEPTH):
  - No write, depth unchanged, new_pc holds, pc_load = 0.
  - ovf_err_o <= 1.
- Accepted RET (ret_i=1, call_i=0, depth>0):
  - new_pc <= entry[depth-1]; depth <= depth - 1; pc_load <= 1.
- Rejected RET (ret_i=1, call_i=0, depth==0):
  - No change, pc_load = 0.
  - unf_err_o <= 1.
- call_i=1 and ret_i=1 in the same cycle:
  - No stack change, new_pc holds, pc_load = 0.
  - ill_err_o <= 1.
- Neither request: all state holds; new_pc keeps its last value.
- Back-to-back operations on consecutive cycles are fully supported; no bubble is required.
  - A RET directly after a CALL returns the address pushed by that CALL.
- Error flags:
  - Stay set until err_clr_i or reset.
  - If err_clr_i coincides with a new error event, that flag ends the cycle set; the other flags clear.
  - Errors never block later legal operations.
- top_addr_o = entry[depth-1] when depth>0, else 0. Combinational from the counter and array; reflects post-edge state.
- Latency: request sampled at edge N; new_pc/pc_load valid after edge N, consumed at edge N+1.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, no requests -> new_pc=0, pc_load=0, depth_o=0, empty_o=1, all error flags 0.
- Single CALL/RET pair:
  - pc=0x00100, call_address=0xABCDE, call_i for 1 cycle -> new_pc=0xABCDE, pc_load pulse, depth_o=1, top_addr_o=0x00101.
  - Then ret_i for 1 cycle -> new_pc=0x00101, pc_load pulse, depth_o=0.
- Nesting and overflow:
  - 16 CALLs with pc=0x00000..0x0000F -> full_o=1, top_addr_o=0x00010.
  - 17th CALL -> ovf_err_o=1, pc_load=0, depth_o=16.
  - Then 16 RETs -> new_pc = 0x00010 down to 0x00001, in LIFO order.
- Underflow and clear:
  - ret_i while empty -> unf_err_o=1, pc_load=0.
  - err_clr_i -> unf_err_o=0.
  - err_clr_i together with another empty RET -> unf_err_o stays 1.
- Wrap and conflict:
  - CALL with pc=0xFFFFF -> top_addr_o=0x00000.
  - call_i=ret_i=1 -> ill_err_o=1, depth_o unchanged.
- Async reset mid-stream: after 3 CALLs, assert rst_n low between clock edges -> depth_o=0, pc_load=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/call_ret_stack_if.sv
// Request/response bundle between the program-flow sequencer and the return-address stack.
// The sequencer drives requests through master; the stack answers through slave.
interface call_ret_stack_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned CNT_W  = 5
);
  logic              call_i;
  logic              ret_i;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] call_address;
  logic              err_clr_i;
  logic [ADDR_W-1:0] new_pc;
  logic              pc_load;
  logic [ADDR_W-1:0] top_addr_o;
  logic [CNT_W-1:0]  depth_o;
  logic              full_o;
  logic              empty_o;
  logic              ovf_err_o;
  logic              unf_err_o;
  logic              ill_err_o;

  modport master (
    output call_i, ret_i, pc, call_address, err_clr_i,
    input  new_pc, pc_load, top_addr_o, depth_o, full_o, empty_o,
           ovf_err_o, unf_err_o, ill_err_o
  );

  modport slave (
    input  call_i, ret_i, pc, call_address, err_clr_i,
    output new_pc, pc_load, top_addr_o, depth_o, full_o, empty_o,
           ovf_err_o, unf_err_o, ill_err_o
  );
endinterface

// File: rtl/call_ret_stack.sv
// Return-address stack: CALL pushes pc+1 and redirects to the target, RET pops and redirects back.
// new_pc/pc_load are registered and feed the PC mux one cycle after the request edge.
module call_ret_stack #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5
) (
  input logic             clk,
  input logic             rst_n,
  call_ret_stack_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  depth;
  logic [ADDR_W-1:0] new_pc_q;
  logic              pc_load_q;
  logic              ovf_q;
  logic              unf_q;
  logic              ill_q;

  logic              full;
  logic              empty;
  logic              only_call;
  logic              only_ret;
  logic              do_call;
  logic              do_ret;
  logic              ovf_ev;
  logic              unf_ev;
  logic              ill_ev;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top_entry;
  logic [ADDR_W-1:0] ret_addr;

  always_comb begin
    full      = (depth == DEPTH_C);
    empty     = (depth == '0);
    only_call = bus.call_i & ~bus.ret_i;
    only_ret  = bus.ret_i & ~bus.call_i;
    do_call   = only_call & ~full;
    do_ret    = only_ret & ~empty;
    ovf_ev    = only_call & full;
    unf_ev    = only_ret & empty;
    ill_ev    = bus.call_i & bus.ret_i;
    // Index width drops the counter MSB: a write only happens below DEPTH, a read only above 0.
    wr_idx    = IDX_W'(depth);
    top_idx   = IDX_W'(depth - 1'b1);
    top_entry = mem[top_idx];
    ret_addr  = bus.pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  // Storage is intentionally not reset; only entries below depth are ever observed.
  always_ff @(posedge clk) begin
    if (do_call) begin
      mem[wr_idx] <= ret_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth     <= '0;
      new_pc_q  <= '0;
      pc_load_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      pc_load_q <= 1'b0;
      if (do_call) begin
        depth     <= depth + 1'b1;
        new_pc_q  <= bus.call_address;
        pc_load_q <= 1'b1;
      end else if (do_ret) begin
        depth     <= depth - 1'b1;
        new_pc_q  <= top_entry;
        pc_load_q <= 1'b1;
      end
      // A fresh error event wins over a coincident clear.
      ovf_q <= ovf_ev | (ovf_q & ~bus.err_clr_i);
      unf_q <= unf_ev | (unf_q & ~bus.err_clr_i);
      ill_q <= ill_ev | (ill_q & ~bus.err_clr_i);
    end
  end

  assign bus.new_pc     = new_pc_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.top_addr_o = empty ? '0 : top_entry;
  assign bus.depth_o    = depth;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.ovf_err_o  = ovf_q;
  assign bus.unf_err_o  = unf_q;
  assign bus.ill_err_o  = ill_q;
endmodule

// File: tb/tb_call_ret_stack.sv
// Directed vector bench for call_ret_stack: a table of request/expected-output records
// plus a hand-written asynchronous reset sequence.
module tb_call_ret_stack;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  typedef struct {
    logic              call;
    logic              ret;
    logic              clr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ca;
    logic [ADDR_W-1:0] np;
    logic              pl;
    logic [CNT_W-1:0]  d;
    logic [ADDR_W-1:0] top;
    logic [2:0]        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vq[$];

  call_ret_stack_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  call_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic c, input logic r, input logic clr,
                              input int pc, input int ca, input int np,
                              input logic pl, input int d, input int top,
                              input logic [2:0] err);
    vec_t v;
    v.call = c;  v.ret = r;  v.clr = clr;
    v.pc   = ADDR_W'(pc);  v.ca = ADDR_W'(ca);  v.np = ADDR_W'(np);
    v.pl   = pl;  v.d = CNT_W'(d);  v.top = ADDR_W'(top);  v.err = err;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic c, input logic r, input logic clr,
                       input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] ca);
    bus.call_i       = c;
    bus.ret_i        = r;
    bus.err_clr_i    = clr;
    bus.pc           = pc;
    bus.call_address = ca;
  endtask

  task automatic check(input string nm, input logic [ADDR_W-1:0] np, input logic pl,
                       input logic [CNT_W-1:0] d, input logic [ADDR_W-1:0] top,
                       input logic [2:0] err);
    logic ef;
    logic ee;
    ef = (d == CNT_W'(DEPTH));
    ee = (d == '0);
    n_vec++;
    if (bus.new_pc !== np || bus.pc_load !== pl || bus.depth_o !== d ||
        bus.top_addr_o !== top || bus.full_o !== ef || bus.empty_o !== ee ||
        {bus.ovf_err_o, bus.unf_err_o, bus.ill_err_o} !== err) begin
      n_err++;
      $display("FAIL %s: got np=%h pl=%b d=%0d top=%h full=%b empty=%b err=%b | want np=%h pl=%b d=%0d top=%h full=%b empty=%b err=%b",
               nm, bus.new_pc, bus.pc_load, bus.depth_o, bus.top_addr_o, bus.full_o,
               bus.empty_o, {bus.ovf_err_o, bus.unf_err_o, bus.ill_err_o},
               np, pl, d, top, ef, ee, err);
    end
  endtask

  initial begin
    // Reset/idle, single pair, pulse width
    add(0,0,0, 0,0,           0,       0, 0, 0,       3'b000);
    add(1,0,0, 'h00100,'hABCDE, 'hABCDE,1, 1, 'h00101, 3'b000);
    add(0,1,0, 0,0,           'h00101, 1, 0, 0,       3'b000);
    add(0,0,0, 0,0,           'h00101, 0, 0, 0,       3'b000);
    // Fill to DEPTH, then one overflow attempt
    for (int i = 0; i < 16; i++)
      add(1,0,0, i,'h20000+i, 'h20000+i, 1, i+1, i+1, 3'b000);
    add(1,0,0, 'h55,'h77777,  'h2000F, 0, 16, 'h10,   3'b100);
    // Drain in LIFO order; overflow flag stays sticky
    for (int k = 0; k < 16; k++)
      add(0,1,0, 0,0, 16-k, 1, 15-k, 15-k, 3'b100);
    add(0,0,1, 0,0, 1, 0, 0, 0, 3'b000);
    // Underflow, clear, clear-vs-event priority
    add(0,1,0, 0,0, 1, 0, 0, 0, 3'b010);
    add(0,0,1, 0,0, 1, 0, 0, 0, 3'b000);
    add(0,1,1, 0,0, 1, 0, 0, 0, 3'b010);
    add(0,0,1, 0,0, 1, 0, 0, 0, 3'b000);
    // Wrap of pc+1, conflicting request, clear alongside a legal call
    add(1,0,0, 'hFFFFF,'h12345, 'h12345, 1, 1, 0,       3'b000);
    add(1,1,0, 5,'h00999,       'h12345, 0, 1, 0,       3'b001);
    add(1,0,1, 'h00200,'h33333, 'h33333, 1, 2, 'h00201, 3'b000);
    // Back-to-back RETs right after the CALL
    add(0,1,0, 0,0, 'h00201, 1, 1, 0, 3'b000);
    add(0,1,0, 0,0, 0,       1, 0, 0, 3'b000);
    add(0,0,0, 0,0, 0,       0, 0, 0, 3'b000);

    drive(0, 0, 0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset", '0, 1'b0, '0, '0, 3'b000);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].call, vq[i].ret, vq[i].clr, vq[i].pc, vq[i].ca);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vq[i].np, vq[i].pl, vq[i].d, vq[i].top, vq[i].err);
    end

    // Asynchronous reset between edges after three CALLs
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(1, 0, 0, ADDR_W'(i), ADDR_W'('h40000 + i));
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, '0, '0);
    #1 check("pre_arst", ADDR_W'('h40003), 1'b1, CNT_W'(3), ADDR_W'(4), 3'b000);
    #1 rst_n = 1'b0;
    #1 check("arst", '0, 1'b0, '0, '0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_arst", '0, 1'b0, '0, '0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
